stdp_synapse: RTL and testbench
===============================

STDP_SYNAPSE -- requirements
Module: stdp_synapse

Interface
REQ-001 SHALL have parameter W_INIT, default 8'd1: weight value loaded at reset.
REQ-002 SHALL have parameter LTP_MAX, default 16: potentiation step applied at dt=1.
REQ-003 SHALL have parameter LTD_MAX, default 16: depression step applied at dt=1.
REQ-004 SHALL have parameter WINDOW, default 4: largest dt that produces an update, range 1..15.
REQ-005 SHALL have one clock; reset is synchronous and active-high.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic updates on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-008 SHALL have port pre_spike, input, 1 bit: presynaptic LIF spike, one-cycle pulse.
REQ-009 SHALL have port post_spike, input, 1 bit: postsynaptic LIF spike, one-cycle pulse.
REQ-010 SHALL have port learn_en, input, 1 bit: high enables weight learning.
REQ-011 SHALL have port weight, output, 8 bits: current synaptic weight, registered.
REQ-012 SHALL have port psc, output, 8 bits: postsynaptic current (weight x pre_spike), registered; drives the postsynaptic LIF current input.
REQ-013 SHALL have port update_valid, output, 1 bit: one-cycle pulse when weight changes due to pairing.
REQ-014 SHALL have port ltp, output, 1 bit: 1 = potentiation and 0 = depression for the last update; held until the next update.
REQ-015 SHALL have port dt, output, 4 bits: spike-pair interval of the last update; held until the next update.

Function
REQ-016 SHALL implement FSM states IDLE, PRE_WAIT and POST_WAIT, plus a 4-bit interval timer.
REQ-017 In IDLE, pre_spike alone SHALL go to PRE_WAIT, post_spike alone SHALL go to POST_WAIT, and both asserted together SHALL remain IDLE with no update (dt=0 is ignored).
REQ-018 On entering a wait state, the timer SHALL load 1.
REQ-019 On each wait-state cycle without a partner spike, the timer SHALL increment; when timer==WINDOW and no partner arrives, the FSM SHALL return to IDLE with no update.
REQ-020 In PRE_WAIT, post_spike SHALL trigger LTP with dt=timer and return to IDLE.
REQ-021 In PRE_WAIT, a lone pre_spike SHALL reload the timer to 1 (nearest-neighbour pairing).
REQ-022 In POST_WAIT, pre_spike SHALL trigger LTD with dt=timer and return to IDLE.
REQ-023 In POST_WAIT, a lone post_spike SHALL reload the timer to 1.
REQ-024 When the partner and a same-type spike coincide in a wait state, the update SHALL apply and the FSM SHALL go to IDLE; the coincident same-type spike is dropped.
REQ-025 Step size SHALL be MAX >> (dt-1), giving 16/8/4/2 for dt=1..4 at defaults; a result of 0 SHALL still pulse update_valid.
REQ-026 Weight arithmetic SHALL use 9 bits and saturate to [0,255]; there is no wrap-around.
REQ-027 weight, update_valid, ltp and dt SHALL update on the clock edge that samples the pairing spike (one-cycle latency to outputs).
REQ-028 psc SHALL be registered as pre_spike ? weight : 0, using the pre-edge weight value.
REQ-029 When learn_en is low, the FSM SHALL be forced to IDLE, weight SHALL be held and update_valid SHALL stay 0, while psc continues to operate.

Reset
REQ-030 On rst high at a clock edge, weight SHALL load W_INIT; state SHALL go to IDLE; timer SHALL clear to 0; and psc, update_valid, ltp and dt SHALL clear to 0.
REQ-031 Reset mid-wait SHALL abandon the pending pairing without an update; reset SHALL take priority over all spikes.

Configuration
REQ-032 With macro STDP_LTD_EN defined, the block SHALL provide POST_WAIT and depression as specified above.
REQ-033 Without STDP_LTD_EN, POST_WAIT and the LTD datapath SHALL be absent: a lone post_spike in IDLE is ignored, ltp is tied to 1, and the weight only increases.

Structure
REQ-034 Package stdp_pkg SHALL hold the state enum type, the 8-bit weight typedef, the 4-bit dt typedef, and the constants WEIGHT_MAX=255 and WEIGHT_MIN=0.
REQ-035 A sub-module stdp_delta_lut SHALL map (dt, max) to the step size; it SHALL return 0 for dt=0 or dt>WINDOW.

Verification
REQ-036 Test: after reset, pre at cycle 0 and post at cycle 2 -> weight 1->9, update_valid one pulse, ltp=1, dt=2.
REQ-037 Test (STDP_LTD_EN defined): post at cycle 0 and pre at cycle 1 -> weight 1->0 (saturated), ltp=0, dt=1.
REQ-038 Test: pre, then post 5 cycles later -> no update_valid, weight stays 1, FSM back in IDLE.
REQ-039 Test: pre and post in the same cycle from IDLE -> no update; then pre/post at dt=1 repeated 17 times from W_INIT=1 -> weight 255, held there.
REQ-040 Test: learn_en=0 with a dt=1 pair -> weight unchanged; pre_spike with weight 9 -> psc=9 on the next cycle and 0 the cycle after.
REQ-041 Test: STDP_LTD_EN undefined, post then pre at dt=1 -> weight stays 1, no update_valid.

Source files
------------

// File: rtl/stdp_pkg.sv
// rtl/stdp_pkg.sv - shared types and constants for the STDP synapse
// Build option: STDP_LTD_EN adds the POST_WAIT state (depression path).
package stdp_pkg;

    typedef logic [7:0] weight_t;
    typedef logic [3:0] dt_t;

    localparam weight_t WEIGHT_MAX = 8'd255;
    localparam weight_t WEIGHT_MIN = 8'd0;

`ifdef STDP_LTD_EN
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PRE_WAIT  = 2'd1,
        ST_POST_WAIT = 2'd2
    } stdp_state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PRE_WAIT  = 2'd1
    } stdp_state_e;
`endif

endpackage

// File: rtl/stdp_delta_lut.sv
// rtl/stdp_delta_lut.sv - maps a spike-pair interval to a weight step
// Ports:
//   dt       - pairing interval (1..WINDOW yields a step)
//   max_step - step applied at dt=1
//   step     - max_step >> (dt-1), or 0 when dt is 0 or beyond WINDOW
module stdp_delta_lut
    import stdp_pkg::*;
#(
    parameter int WINDOW = 4
) (
    input  logic [3:0] dt,
    input  logic [7:0] max_step,
    output logic [7:0] step
);

    localparam dt_t WINDOW_DT = WINDOW[3:0];

    always_comb begin
        step = WEIGHT_MIN;
        if ((dt != 4'd0) && (dt <= WINDOW_DT)) begin
            step = max_step >> (dt - 4'd1);
        end
    end

endmodule

// File: rtl/stdp_synapse.sv
// rtl/stdp_synapse.sv - pair-based STDP synapse with nearest-neighbour pairing
// Build option: STDP_LTD_EN enables depression (post-before-pre pairing);
// without it only potentiation exists and ltp is tied high.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   pre_spike     - presynaptic spike pulse
//   post_spike    - postsynaptic spike pulse
//   learn_en      - enables weight learning
//   weight        - current synaptic weight (registered)
//   psc           - registered pre_spike ? weight : 0
//   update_valid  - one-cycle pulse on every pairing update
//   ltp, dt       - direction and interval of the last update, held
module stdp_synapse
    import stdp_pkg::*;
#(
    parameter logic [7:0] W_INIT  = 8'd1,
    parameter int         LTP_MAX = 16,
    parameter int         LTD_MAX = 16,
    parameter int         WINDOW  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pre_spike,
    input  logic       post_spike,
    input  logic       learn_en,
    output logic [7:0] weight,
    output logic [7:0] psc,
    output logic       update_valid,
    output logic       ltp,
    output logic [3:0] dt
);

    localparam dt_t WINDOW_DT = WINDOW[3:0];

    stdp_state_e state_q, state_d;
    dt_t         timer_q, timer_d;
    weight_t     weight_q, weight_d;
    weight_t     psc_q, psc_d;
    logic        uv_q, uv_d;
    dt_t         dt_q, dt_d;

    weight_t     ltp_step;
    logic [8:0]  ltp_sum;

    stdp_delta_lut #(.WINDOW(WINDOW)) u_ltp_lut (
        .dt       (timer_q),
        .max_step (LTP_MAX[7:0]),
        .step     (ltp_step)
    );

    assign ltp_sum = {1'b0, weight_q} + {1'b0, ltp_step};

`ifdef STDP_LTD_EN
    logic        ltp_q, ltp_d;
    weight_t     ltd_step;
    logic [8:0]  ltd_diff;

    stdp_delta_lut #(.WINDOW(WINDOW)) u_ltd_lut (
        .dt       (timer_q),
        .max_step (LTD_MAX[7:0]),
        .step     (ltd_step)
    );

    // Borrow out of bit 8 means the step exceeded the weight: clamp at zero.
    assign ltd_diff = {1'b0, weight_q} - {1'b0, ltd_step};
`endif

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        weight_d = weight_q;
        psc_d    = pre_spike ? weight_q : WEIGHT_MIN;
        uv_d     = 1'b0;
        dt_d     = dt_q;
`ifdef STDP_LTD_EN
        ltp_d    = ltp_q;
`endif
        if (!learn_en) begin
            state_d = ST_IDLE;
            timer_d = 4'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    timer_d = 4'd0;
                    // Coincident pre and post is dt=0 and is not a pairing.
                    if (pre_spike && !post_spike) begin
                        state_d = ST_PRE_WAIT;
                        timer_d = 4'd1;
                    end
`ifdef STDP_LTD_EN
                    else if (post_spike && !pre_spike) begin
                        state_d = ST_POST_WAIT;
                        timer_d = 4'd1;
                    end
`endif
                end
                ST_PRE_WAIT: begin
                    if (post_spike) begin
                        // Partner wins; a coincident pre is dropped.
                        weight_d = ltp_sum[8] ? WEIGHT_MAX : ltp_sum[7:0];
                        uv_d     = 1'b1;
                        dt_d     = timer_q;
`ifdef STDP_LTD_EN
                        ltp_d    = 1'b1;
`endif
                        state_d  = ST_IDLE;
                        timer_d  = 4'd0;
                    end else if (pre_spike) begin
                        timer_d = 4'd1;
                    end else if (timer_q == WINDOW_DT) begin
                        state_d = ST_IDLE;
                        timer_d = 4'd0;
                    end else begin
                        timer_d = timer_q + 4'd1;
                    end
                end
`ifdef STDP_LTD_EN
                ST_POST_WAIT: begin
                    if (pre_spike) begin
                        weight_d = ltd_diff[8] ? WEIGHT_MIN : ltd_diff[7:0];
                        uv_d     = 1'b1;
                        dt_d     = timer_q;
                        ltp_d    = 1'b0;
                        state_d  = ST_IDLE;
                        timer_d  = 4'd0;
                    end else if (post_spike) begin
                        timer_d = 4'd1;
                    end else if (timer_q == WINDOW_DT) begin
                        state_d = ST_IDLE;
                        timer_d = 4'd0;
                    end else begin
                        timer_d = timer_q + 4'd1;
                    end
                end
`endif
                default: begin
                    state_d = ST_IDLE;
                    timer_d = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            timer_q  <= 4'd0;
            weight_q <= W_INIT;
            psc_q    <= WEIGHT_MIN;
            uv_q     <= 1'b0;
            dt_q     <= 4'd0;
`ifdef STDP_LTD_EN
            ltp_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            weight_q <= weight_d;
            psc_q    <= psc_d;
            uv_q     <= uv_d;
            dt_q     <= dt_d;
`ifdef STDP_LTD_EN
            ltp_q    <= ltp_d;
`endif
        end
    end

    assign weight       = weight_q;
    assign psc          = psc_q;
    assign update_valid = uv_q;
    assign dt           = dt_q;
`ifdef STDP_LTD_EN
    assign ltp          = ltp_q;
`else
    assign ltp          = 1'b1;
`endif

endmodule

// File: tb/tb_stdp_synapse.sv
// tb/tb_stdp_synapse.sv - self-checking bench for stdp_synapse (timestamp-based reference model)
module tb_stdp_synapse;

`ifdef STDP_LTD_EN
    localparam bit LTD = 1'b1;
`else
    localparam bit LTD = 1'b0;
`endif
    localparam int W_INIT = 1;
    localparam int LTP_MAX = 16;
    localparam int LTD_MAX = 16;
    localparam int WINDOW = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       pre_spike;
    logic       post_spike;
    logic       learn_en;
    logic [7:0] weight;
    logic [7:0] psc;
    logic       update_valid;
    logic       ltp;
    logic [3:0] dt;

    int n_checks = 0;
    int n_errors = 0;

    stdp_synapse dut (
        .clk          (clk),
        .rst          (rst),
        .pre_spike    (pre_spike),
        .post_spike   (post_spike),
        .learn_en     (learn_en),
        .weight       (weight),
        .psc          (psc),
        .update_valid (update_valid),
        .ltp          (ltp),
        .dt           (dt)
    );

    always #5 clk = ~clk;

    // Reference model: remembers the edge index of the last unpaired spike
    // and pairs by timestamp difference.
    int  m_weight, m_psc, m_uv, m_ltp, m_dt;
    bit  m_init = 1'b0;
    int  edge_n = 0;
    int  pend_kind = 0;   // 0 none, 1 pre pending, 2 post pending
    int  pend_t = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_weight  = W_INIT;
            m_psc     = 0;
            m_uv      = 0;
            m_ltp     = LTD ? 0 : 1;
            m_dt      = 0;
            pend_kind = 0;
            m_init    = 1'b1;
        end else begin
            int age;
            m_psc = pre_spike ? m_weight : 0;
            m_uv  = 0;
            if (!learn_en) begin
                pend_kind = 0;
            end else begin
                age = edge_n - pend_t;
                if (pend_kind != 0 && age > WINDOW) pend_kind = 0;
                if (pend_kind == 1 && post_spike) begin
                    m_weight = m_weight + (LTP_MAX >> (age - 1));
                    if (m_weight > 255) m_weight = 255;
                    m_uv = 1; m_dt = age; m_ltp = 1; pend_kind = 0;
                end else if (LTD && pend_kind == 2 && pre_spike) begin
                    m_weight = m_weight - (LTD_MAX >> (age - 1));
                    if (m_weight < 0) m_weight = 0;
                    m_uv = 1; m_dt = age; m_ltp = 0; pend_kind = 0;
                end else if (pend_kind == 0) begin
                    if (pre_spike && !post_spike) begin
                        pend_kind = 1; pend_t = edge_n;
                    end else if (LTD && post_spike && !pre_spike) begin
                        pend_kind = 2; pend_t = edge_n;
                    end
                end else if (pend_kind == 1 && pre_spike) begin
                    pend_t = edge_n;
                end else if (pend_kind == 2 && post_spike) begin
                    pend_t = edge_n;
                end
            end
        end
        edge_n++;
    end

    task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_init) begin
            chk("cmp_weight", {1'b0, weight}, m_weight[8:0]);
            chk("cmp_psc", {1'b0, psc}, m_psc[8:0]);
            chk("cmp_update_valid", {8'd0, update_valid}, m_uv[8:0]);
            chk("cmp_ltp", {8'd0, ltp}, m_ltp[8:0]);
            chk("cmp_dt", {5'd0, dt}, m_dt[8:0]);
        end
    end

    task automatic cyc(input logic p, input logic q);
        pre_spike  = p;
        post_spike = q;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(1'b0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; pre_spike = 1'b0; post_spike = 1'b0; learn_en = 1'b1;
        @(negedge clk);
        do_reset();
        chk("rst_weight", {1'b0, weight}, 9'd1);
        chk("rst_psc", {1'b0, psc}, 9'd0);
        chk("rst_uv", {8'd0, update_valid}, 9'd0);
        chk("rst_dt", {5'd0, dt}, 9'd0);
        chk("rst_ltp", {8'd0, ltp}, LTD ? 9'd0 : 9'd1);

        // pre at 0, post at 2
        cyc(1, 0); cyc(0, 0); cyc(0, 1);
        chk("ltp2_uv", {8'd0, update_valid}, 9'd1);
        chk("ltp2_weight", {1'b0, weight}, 9'd9);
        chk("ltp2_ltp", {8'd0, ltp}, 9'd1);
        chk("ltp2_dt", {5'd0, dt}, 9'd2);
        cyc(0, 0);
        chk("ltp2_uv_drop", {8'd0, update_valid}, 9'd0);
        chk("ltp2_dt_held", {5'd0, dt}, 9'd2);

        // window edge dt=4: step 2
        cyc(1, 0);
        chk("psc_pre", {1'b0, psc}, 9'd9);
        cyc(0, 0); cyc(0, 0); cyc(0, 0); cyc(0, 1);
        chk("ltp4_weight", {1'b0, weight}, 9'd11);
        chk("ltp4_dt", {5'd0, dt}, 9'd4);

        // post 5 cycles after pre: outside window
        do_reset();
        cyc(1, 0); cyc(0, 0); cyc(0, 0); cyc(0, 0); cyc(0, 0); cyc(0, 1);
        chk("late_uv", {8'd0, update_valid}, 9'd0);
        chk("late_weight", {1'b0, weight}, 9'd1);
        repeat (6) cyc(0, 0);
        cyc(1, 0); cyc(0, 1);
        chk("after_late_dt", {5'd0, dt}, 9'd1);
        chk("after_late_weight", {1'b0, weight}, 9'd17);

        // nearest neighbour: second pre restarts the interval
        do_reset();
        cyc(1, 0); cyc(0, 0); cyc(1, 0); cyc(0, 1);
        chk("nn_dt", {5'd0, dt}, 9'd1);
        chk("nn_weight", {1'b0, weight}, 9'd17);

        // partner coincident with same-type spike
        cyc(1, 0); cyc(1, 1);
        chk("coinc_uv", {8'd0, update_valid}, 9'd1);
        chk("coinc_weight", {1'b0, weight}, 9'd33);
        cyc(0, 1);
        chk("coinc_after_uv", {8'd0, update_valid}, 9'd0);
        repeat (6) cyc(0, 0);

        // reset mid-wait, spike during reset ignored
        do_reset();
        cyc(1, 0);
        rst = 1'b1;
        cyc(0, 1);
        rst = 1'b0;
        chk("rst_mid_uv", {8'd0, update_valid}, 9'd0);
        cyc(0, 0);
        chk("rst_mid_weight", {1'b0, weight}, 9'd1);

        // same-cycle pair ignored, then saturation at 255
        do_reset();
        cyc(1, 1);
        chk("dt0_uv", {8'd0, update_valid}, 9'd0);
        chk("dt0_weight", {1'b0, weight}, 9'd1);
        for (int i = 0; i < 17; i++) begin
            cyc(1, 0); cyc(0, 1);
        end
        chk("sat_weight", {1'b0, weight}, 9'd255);
        chk("sat_uv", {8'd0, update_valid}, 9'd1);
        cyc(0, 0);
        chk("sat_hold", {1'b0, weight}, 9'd255);

        // learn_en low: no learning, psc still works
        do_reset();
        cyc(1, 0); cyc(0, 0); cyc(0, 1);
        chk("le_pre_weight", {1'b0, weight}, 9'd9);
        learn_en = 1'b0;
        cyc(1, 0);
        chk("le_psc", {1'b0, psc}, 9'd9);
        cyc(0, 1);
        chk("le_psc_clear", {1'b0, psc}, 9'd0);
        chk("le_weight", {1'b0, weight}, 9'd9);
        chk("le_uv", {8'd0, update_valid}, 9'd0);
        learn_en = 1'b1;
        cyc(0, 0);

        // post then pre at dt=1
        do_reset();
        cyc(0, 1); cyc(1, 0);
        chk("ltd_psc", {1'b0, psc}, 9'd1);
        chk("ltd_weight", {1'b0, weight}, LTD ? 9'd0 : 9'd1);
        chk("ltd_uv", {8'd0, update_valid}, LTD ? 9'd1 : 9'd0);
        chk("ltd_ltp", {8'd0, ltp}, LTD ? 9'd0 : 9'd1);
        chk("ltd_dt", {5'd0, dt}, LTD ? 9'd1 : 9'd0);

        // mixed sequence, checked only by the model
        do_reset();
        cyc(0, 1); cyc(0, 0); cyc(0, 0); cyc(1, 0); cyc(0, 0);
        cyc(0, 1); cyc(0, 1); cyc(0, 0); cyc(1, 1); cyc(1, 0);
        cyc(0, 0); cyc(0, 0); cyc(0, 1); cyc(1, 0); cyc(0, 0);
        repeat (6) cyc(0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
